// File: rtl/display_timing_pkg.sv
// Shared 480p60 raster constants and coordinate type for the timing generator and paint blocks.
// Constants only; no logic, no latency.
package display_pkg;

   localparam int CORDW = 16;
   typedef logic signed [CORDW-1:0] coord_t;

   localparam int   H_RES  = 640;
   localparam int   V_RES  = 480;
   localparam int   H_FP   = 16;
   localparam int   H_SYNC = 96;
   localparam int   H_BP   = 48;
   localparam int   V_FP   = 10;
   localparam int   V_SYNC = 2;
   localparam int   V_BP   = 33;
   localparam logic H_POL  = 1'b0;
   localparam logic V_POL  = 1'b0;

   function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/display_timing_if.sv
// Raster timing bundle: coordinates, strobes, syncs and their delayed copies.
// Pure wiring; the generator drives through master, paint/output stages read through slave.
interface display_timing_if;
   import display_pkg::*;

   coord_t      sx;
   coord_t      sy;
   logic        line;
   logic        frame;
   logic        de;
   logic        hsync;
   logic        vsync;
   logic        hsync_d;
   logic        vsync_d;
   logic        de_d;
   logic [15:0] frame_cnt;

   modport master (output sx, sy, line, frame, de, hsync, vsync, hsync_d, vsync_d, de_d, frame_cnt);
   modport slave  (input  sx, sy, line, frame, de, hsync, vsync, hsync_d, vsync_d, de_d, frame_cnt);

endinterface

// File: rtl/display_timing_sig.sv
// Fixed-depth shift register with async active-low reset; DEPTH=0 degenerates to a wire.
// Latency DEPTH cycles; no backpressure, data advances every clock.
module sig_delay #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_dat,
   output logic [WIDTH-1:0] o_dat
);

   if (DEPTH == 0) begin : g_wire
      assign o_dat = i_dat;
   end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
         end else begin
            r_stage[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
         end
      end

      assign o_dat = r_stage[DEPTH-1];
   end

endmodule

// File: rtl/display_timing.sv
// Pixel-clock raster generator: signed sx/sy, line/frame strobes, DE, syncs and delayed sync/DE copies.
// All outputs registered off the next-position decode; free-running, no backpressure.
module display_timing #(
   parameter int   CORDW    = display_pkg::CORDW,
   parameter int   H_RES    = display_pkg::H_RES,
   parameter int   V_RES    = display_pkg::V_RES,
   parameter int   H_FP     = display_pkg::H_FP,
   parameter int   H_SYNC   = display_pkg::H_SYNC,
   parameter int   H_BP     = display_pkg::H_BP,
   parameter int   V_FP     = display_pkg::V_FP,
   parameter int   V_SYNC   = display_pkg::V_SYNC,
   parameter int   V_BP     = display_pkg::V_BP,
   parameter logic H_POL    = display_pkg::H_POL,
   parameter logic V_POL    = display_pkg::V_POL,
   parameter int   SYNC_DLY = 1
) (
   input  logic                    clk_pix,
   input  logic                    rst_pix_n,
   display_timing_if.master        o_tim
);

   typedef display_pkg::coord_t coord_t;

   localparam coord_t H_STA  = coord_t'(-(H_FP + H_SYNC + H_BP));
   localparam coord_t V_STA  = coord_t'(-(V_FP + V_SYNC + V_BP));
   localparam coord_t HS_STA = coord_t'(-(H_SYNC + H_BP));
   localparam coord_t HS_END = coord_t'(-H_BP - 1);
   localparam coord_t VS_STA = coord_t'(-(V_SYNC + V_BP));
   localparam coord_t VS_END = coord_t'(-V_BP - 1);
   localparam coord_t H_LAST = coord_t'(H_RES - 1);
   localparam coord_t V_LAST = coord_t'(V_RES - 1);
   localparam coord_t ZERO   = coord_t'(0);

   if (SYNC_DLY < 0 || SYNC_DLY > 8 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_FP == 0 || V_SYNC == 0 || V_BP == 0 || CORDW != display_pkg::CORDW) begin : g_bad_param
      $error("display_timing: illegal timing parameters");
   end

   coord_t      r_sx, r_sy;
   logic        r_line, r_frame, r_de, r_hsync, r_vsync;
   logic [15:0] r_frame_cnt;
   coord_t      w_sx_nxt, w_sy_nxt;
   logic        w_frame_nxt;
   logic [2:0]  w_sync_d;

   always_comb begin
      w_sx_nxt = r_sx + coord_t'(1);
      w_sy_nxt = r_sy;
      if (r_sx == H_LAST) begin
         w_sx_nxt = H_STA;
         w_sy_nxt = (r_sy == V_LAST) ? V_STA : r_sy + coord_t'(1);
      end
   end

   assign w_frame_nxt = (w_sx_nxt == H_STA) && (w_sy_nxt == V_STA);

   // Everything is decoded from the next position so every output describes the same pixel as sx/sy.
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         r_sx        <= H_STA;
         r_sy        <= V_STA;
         r_line      <= 1'b0;
         r_frame     <= 1'b0;
         r_de        <= 1'b0;
         r_hsync     <= ~H_POL;
         r_vsync     <= ~V_POL;
         r_frame_cnt <= '0;
      end else begin
         r_sx    <= w_sx_nxt;
         r_sy    <= w_sy_nxt;
         r_line  <= (w_sx_nxt == H_STA);
         r_frame <= w_frame_nxt;
         r_de    <= display_pkg::in_span(w_sx_nxt, ZERO, H_LAST) &&
                    display_pkg::in_span(w_sy_nxt, ZERO, V_LAST);
         r_hsync <= display_pkg::in_span(w_sx_nxt, HS_STA, HS_END) ? H_POL : ~H_POL;
         r_vsync <= display_pkg::in_span(w_sy_nxt, VS_STA, VS_END) ? V_POL : ~V_POL;
         if (w_frame_nxt) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   sig_delay #(
      .WIDTH   (3),
      .DEPTH   (SYNC_DLY),
      .RST_VAL ({~H_POL, ~V_POL, 1'b0})
   ) u_sync_dly (
      .i_clk   (clk_pix),
      .i_rst_n (rst_pix_n),
      .i_dat   ({r_hsync, r_vsync, r_de}),
      .o_dat   (w_sync_d)
   );

   assign o_tim.sx        = r_sx;
   assign o_tim.sy        = r_sy;
   assign o_tim.line      = r_line;
   assign o_tim.frame     = r_frame;
   assign o_tim.de        = r_de;
   assign o_tim.hsync     = r_hsync;
   assign o_tim.vsync     = r_vsync;
   assign o_tim.hsync_d   = w_sync_d[2];
   assign o_tim.vsync_d   = w_sync_d[1];
   assign o_tim.de_d      = w_sync_d[0];
   assign o_tim.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_display_timing.sv
// Directed bench: two shrunken rasters (15x8 total, SYNC_DLY 1 and 0) plus the default 800x525 raster.
// Small raster A: H_STA=-7, HS=-5..-3 active-high, V_STA=-4, VS=-3..-2 active-low, frame = 120 clocks.
module tb_display_timing;

   logic clk = 1'b0;
   logic rst_n;
   int   vecs = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   display_timing_if a_if ();
   display_timing_if b_if ();
   display_timing_if c_if ();

   display_timing #(
      .H_RES(8), .V_RES(4), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_FP(1), .V_SYNC(2), .V_BP(1), .H_POL(1'b1), .V_POL(1'b0), .SYNC_DLY(1)
   ) u_a (.clk_pix(clk), .rst_pix_n(rst_n), .o_tim(a_if));

   display_timing #(
      .H_RES(8), .V_RES(4), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_FP(1), .V_SYNC(2), .V_BP(1), .H_POL(1'b0), .V_POL(1'b1), .SYNC_DLY(0)
   ) u_b (.clk_pix(clk), .rst_pix_n(rst_n), .o_tim(b_if));

   display_timing u_c (.clk_pix(clk), .rst_pix_n(rst_n), .o_tim(c_if));

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      logic [2:0] prev_a, prev_c;
      int a_first_frame, a_de_cnt, a_hs_cnt, a_vs_cnt, a_line_cnt, a_frm_cnt, a_de_neg;
      int a_hs0_cnt, a_hs0_min, a_hs0_max, a_de0_cnt, a_de0_min, a_de0_max, a_vs_min, a_vs_max;
      int a_dly_bad, b_dly_bad, c_dly_bad, c_hs_cnt, c_hs_min, c_hs_max, c_de_cnt, c_line_cnt;
      int a_restart_frame;

      a_first_frame = -1; a_restart_frame = -1;
      a_de_cnt = 0; a_hs_cnt = 0; a_vs_cnt = 0; a_line_cnt = 0; a_frm_cnt = 0; a_de_neg = 0;
      a_hs0_cnt = 0; a_hs0_min = 1000; a_hs0_max = -1000;
      a_de0_cnt = 0; a_de0_min = 1000; a_de0_max = -1000;
      a_vs_min = 1000; a_vs_max = -1000;
      a_dly_bad = 0; b_dly_bad = 0; c_dly_bad = 0;
      c_hs_cnt = 0; c_hs_min = 1000; c_hs_max = -1000; c_de_cnt = 0; c_line_cnt = 0;

      // ---- reset and release ----
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("a_rst_sx", a_if.sx, -7);
      chk("a_rst_sy", a_if.sy, -4);
      chk("a_rst_line", a_if.line, 0);
      chk("a_rst_frame", a_if.frame, 0);
      chk("a_rst_de", a_if.de, 0);
      chk("a_rst_frame_cnt", a_if.frame_cnt, 0);
      chk("a_rst_hsync", a_if.hsync, 0);
      chk("a_rst_vsync", a_if.vsync, 1);
      chk("a_rst_hsync_d", a_if.hsync_d, 0);
      chk("a_rst_vsync_d", a_if.vsync_d, 1);
      chk("a_rst_de_d", a_if.de_d, 0);
      chk("b_rst_hsync_d", b_if.hsync_d, 1);
      chk("b_rst_vsync_d", b_if.vsync_d, 0);
      chk("c_rst_sx", c_if.sx, -160);
      chk("c_rst_sy", c_if.sy, -45);
      chk("c_rst_hsync", c_if.hsync, 1);
      chk("c_rst_vsync", c_if.vsync, 1);
      chk("c_rst_frame_cnt", c_if.frame_cnt, 0);

      // ---- 800 clocks: one full default line, several small frames ----
      prev_a = {a_if.hsync, a_if.vsync, a_if.de};
      prev_c = {c_if.hsync, c_if.vsync, c_if.de};
      for (int k = 1; k <= 800; k++) begin
         @(negedge clk);
         if (k == 1) begin
            chk("a_step1_sx", a_if.sx, -6);
            chk("a_step1_line", a_if.line, 0);
            chk("c_step1_sx", c_if.sx, -159);
         end
         if (k == 15) begin
            chk("a_line1_strobe", a_if.line, 1);
            chk("a_line1_sy", a_if.sy, -3);
         end
         if (k == 119) begin
            chk("a_last_sx", a_if.sx, 7);
            chk("a_last_sy", a_if.sy, 3);
            chk("a_last_de", a_if.de, 1);
            chk("a_last_frame_cnt", a_if.frame_cnt, 0);
         end
         if (k == 120) begin
            chk("a_wrap_sx", a_if.sx, -7);
            chk("a_wrap_sy", a_if.sy, -4);
            chk("a_wrap_line", a_if.line, 1);
            chk("a_wrap_frame", a_if.frame, 1);
            chk("a_wrap_frame_cnt", a_if.frame_cnt, 1);
         end
         if (a_if.frame && a_first_frame < 0) a_first_frame = k;
         if (k >= 16 && k <= 135) begin
            a_de_cnt   += int'(a_if.de);
            a_hs_cnt   += int'(a_if.hsync);
            a_vs_cnt   += int'(!a_if.vsync);
            a_line_cnt += int'(a_if.line);
            a_frm_cnt  += int'(a_if.frame);
            if (a_if.de && a_if.sy < 0) a_de_neg++;
            if (a_if.hsync && a_if.sy == 0) begin
               a_hs0_cnt++;
               if (int'(a_if.sx) < a_hs0_min) a_hs0_min = int'(a_if.sx);
               if (int'(a_if.sx) > a_hs0_max) a_hs0_max = int'(a_if.sx);
            end
            if (a_if.de && a_if.sy == 0) begin
               a_de0_cnt++;
               if (int'(a_if.sx) < a_de0_min) a_de0_min = int'(a_if.sx);
               if (int'(a_if.sx) > a_de0_max) a_de0_max = int'(a_if.sx);
            end
            if (!a_if.vsync) begin
               if (int'(a_if.sy) < a_vs_min) a_vs_min = int'(a_if.sy);
               if (int'(a_if.sy) > a_vs_max) a_vs_max = int'(a_if.sy);
            end
         end
         if ({a_if.hsync_d, a_if.vsync_d, a_if.de_d} !== prev_a) a_dly_bad++;
         if ({b_if.hsync_d, b_if.vsync_d, b_if.de_d} !== {b_if.hsync, b_if.vsync, b_if.de}) b_dly_bad++;
         if ({c_if.hsync_d, c_if.vsync_d, c_if.de_d} !== prev_c) c_dly_bad++;
         prev_a = {a_if.hsync, a_if.vsync, a_if.de};
         prev_c = {c_if.hsync, c_if.vsync, c_if.de};
         if (!c_if.hsync) begin
            c_hs_cnt++;
            if (int'(c_if.sx) < c_hs_min) c_hs_min = int'(c_if.sx);
            if (int'(c_if.sx) > c_hs_max) c_hs_max = int'(c_if.sx);
         end
         c_de_cnt   += int'(c_if.de);
         c_line_cnt += int'(c_if.line);
      end

      chk("a_first_frame_cycle", a_first_frame, 120);
      chk("a_frame_de_count", a_de_cnt, 32);
      chk("a_frame_hsync_count", a_hs_cnt, 24);
      chk("a_frame_vsync_count", a_vs_cnt, 30);
      chk("a_frame_line_count", a_line_cnt, 8);
      chk("a_frame_frame_count", a_frm_cnt, 1);
      chk("a_de_in_blank", a_de_neg, 0);
      chk("a_hs_row0_count", a_hs0_cnt, 3);
      chk("a_hs_row0_min_sx", a_hs0_min, -5);
      chk("a_hs_row0_max_sx", a_hs0_max, -3);
      chk("a_de_row0_count", a_de0_cnt, 8);
      chk("a_de_row0_min_sx", a_de0_min, 0);
      chk("a_de_row0_max_sx", a_de0_max, 7);
      chk("a_vs_min_sy", a_vs_min, -3);
      chk("a_vs_max_sy", a_vs_max, -2);
      chk("a_frame_cnt_800", a_if.frame_cnt, 6);
      chk("a_dly1_mismatches", a_dly_bad, 0);
      chk("b_dly0_mismatches", b_dly_bad, 0);
      chk("c_dly1_mismatches", c_dly_bad, 0);
      chk("c_hsync_low_count", c_hs_cnt, 96);
      chk("c_hsync_min_sx", c_hs_min, -144);
      chk("c_hsync_max_sx", c_hs_max, -49);
      chk("c_de_first_line", c_de_cnt, 0);
      chk("c_line_count", c_line_cnt, 1);
      chk("c_line800_strobe", c_if.line, 1);
      chk("c_line800_sx", c_if.sx, -160);
      chk("c_line800_sy", c_if.sy, -44);
      chk("c_line800_frame", c_if.frame, 0);

      // ---- async reset mid-line, between clock edges ----
      repeat (5) @(negedge clk);
      chk("a_pre_rst_sx", a_if.sx, 3);
      chk("a_pre_rst_sy", a_if.sy, 1);
      chk("a_pre_rst_de_d", a_if.de_d, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("a_mid_rst_sx", a_if.sx, -7);
      chk("a_mid_rst_sy", a_if.sy, -4);
      chk("a_mid_rst_de", a_if.de, 0);
      chk("a_mid_rst_de_d", a_if.de_d, 0);
      chk("a_mid_rst_frame_cnt", a_if.frame_cnt, 0);
      chk("c_mid_rst_sx", c_if.sx, -160);

      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 130; k++) begin
         @(negedge clk);
         if (k == 1) chk("a_restart_step1_sx", a_if.sx, -6);
         if (a_if.frame && a_restart_frame < 0) a_restart_frame = k;
      end
      chk("a_restart_first_frame", a_restart_frame, 120);
      chk("a_restart_frame_cnt", a_if.frame_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
